// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Optional feature macro: IMEM_PARITY_EN (adds one even-parity bit per stored word).
package imem_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 9;

`ifdef IMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] pc;
    } stage_t;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_parity(input logic [DEF_INSTR_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port program RAM: written during program load, read synchronously while running.
// The word width includes the parity bit when IMEM_PARITY_EN is defined (chosen by the parent).
module imem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage array is deliberately not reset so the program survives a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only updates on an accepted fetch so it holds during stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: LOAD/RUN control, fixed-latency fetch pipeline,
// stall hold and branch flush. Optional macro: IMEM_PARITY_EN (sticky parity check).
module imem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int LAT     = 2
) (
    input  logic               f_clk,
    input  logic               rst_n,
    input  logic               req_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               ready_o,
    input  logic               flush_i,
    input  logic               stall_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               ld_en_i,
    input  logic [ADDR_W-1:0]  ld_addr_i,
    input  logic [INSTR_W-1:0] ld_data_i,
    input  logic               ld_done_i,
    output logic               run_o,
    output logic               parity_err_o
);

    localparam int RAM_W = INSTR_W + PAR_W;

    state_t             state;
    state_t             next_state;
    logic               accept;
    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [RAM_W-1:0]   ram_wdata;
    logic [RAM_W-1:0]   ram_rdata;
    logic [RAM_W-1:0]   out_data;
    stage_t             stg [LAT];

    // State register; only reset brings the block back to LOAD.
    always_ff @(posedge f_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: end of program load moves to RUN, RUN is terminal.
    always_comb begin
        next_state = state;
        if (state == S_LOAD && ld_done_i) begin
            next_state = S_RUN;
        end
    end

    assign run_o    = (state == S_RUN);
    assign ready_o  = run_o && !stall_i;
    assign accept   = req_i && ready_o;
    assign ram_we   = (state == S_LOAD) && ld_en_i;
    assign ram_addr = run_o ? pc_i : ld_addr_i;

`ifdef IMEM_PARITY_EN
    assign ram_wdata = {even_parity(ld_data_i), ld_data_i};
`else
    assign ram_wdata = ld_data_i;
`endif

    imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (RAM_W)
    ) u_ram (
        .clk   (f_clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (accept),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Valid/pc pipeline: flush kills everything in flight but still admits the branch target.
    always_ff @(posedge f_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) begin
                stg[k] <= '0;
            end
        end else if (flush_i) begin
            stg[0].valid <= accept;
            if (accept) begin
                stg[0].pc <= pc_i;
            end
            for (int k = 1; k < LAT; k++) begin
                stg[k].valid <= 1'b0;
            end
        end else if (!stall_i) begin
            stg[0].valid <= accept;
            if (accept) begin
                stg[0].pc <= pc_i;
            end
            for (int k = 1; k < LAT; k++) begin
                stg[k] <= stg[k-1];
            end
        end
    end

    if (LAT == 1) begin : g_nodly
        assign out_data = ram_rdata;
    end else begin : g_dly
        logic [RAM_W-1:0] dly [1:LAT-1];

        // Data delay line behind the RAM read register; frozen while stalled.
        always_ff @(posedge f_clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 1; k < LAT; k++) begin
                    dly[k] <= '0;
                end
            end else if (!stall_i) begin
                dly[1] <= ram_rdata;
                for (int k = 2; k < LAT; k++) begin
                    dly[k] <= dly[k-1];
                end
            end
        end

        assign out_data = dly[LAT-1];
    end

    assign instr_valid_o = stg[LAT-1].valid;
    assign instr_pc_o    = stg[LAT-1].pc;
    assign instr_o       = out_data[INSTR_W-1:0];

`ifdef IMEM_PARITY_EN
    logic par_bad;
    logic par_sticky;

    assign par_bad = stg[LAT-1].valid &&
                     (even_parity(out_data[INSTR_W-1:0]) != out_data[INSTR_W]);

    // Sticky error flag; the live term lets the flag show in the same cycle as the bad word.
    always_ff @(posedge f_clk or negedge rst_n) begin
        if (!rst_n) begin
            par_sticky <= 1'b0;
        end else if (par_bad) begin
            par_sticky <= 1'b1;
        end
    end

    assign parity_err_o = par_sticky | par_bad;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
